// File: rtl/goertzel_pkg.sv
// Shared types and constants for the Goertzel frame controller.
// Contents: FSM state enum, default widths and frame length, index-width helper.
package goertzel_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StMag1,
        StMag2,
        StOut
    } state_e;

    localparam int unsigned DefIw = 12;
    localparam int unsigned DefN  = 126;
    localparam int unsigned DefOw = 32;

    // Width of a sample index counting 0..n-1; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/goertzel_frame_ctrl_if.sv
// Stream bundle for the Goertzel frame controller.
//   sample_valid / sample / sample_ready : input sample stream (i_sample_valid, i_sample,
//                                          o_sample_ready at the controller)
//   power_valid / power / power_ready    : result stream (o_power_valid, o_power,
//                                          i_power_ready at the controller)
// master = sample source / result sink, slave = the controller.
interface goertzel_frame_ctrl_if #(
    parameter int unsigned IW = 12,
    parameter int unsigned PW = 64
) ();

    logic                 sample_valid;
    logic signed [IW-1:0] sample;
    logic                 sample_ready;
    logic                 power_valid;
    logic [PW-1:0]        power;
    logic                 power_ready;

    modport master (
        output sample_valid, sample, power_ready,
        input  sample_ready, power_valid, power
    );

    modport slave (
        input  sample_valid, sample, power_ready,
        output sample_ready, power_valid, power
    );

endinterface

// File: rtl/goertzel_power.sv
// Two-stage pipelined s1^2 + s2^2 - s1*s2 unit.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_en           : capture products of i_s1/i_s2 this edge; the sum follows one edge later
//   i_s1, i_s2     : signed recursion state (OW bits)
//   o_power        : registered result, low PW bits of the (2*OW+1)-bit signed sum
module goertzel_power #(
    parameter int unsigned OW = 32,
    parameter int unsigned PW = 2 * OW
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic signed [OW-1:0] i_s1,
    input  logic signed [OW-1:0] i_s2,
    output logic [PW-1:0]        o_power
);

    logic signed [2*OW-1:0] s1_w;
    logic signed [2*OW-1:0] s2_w;
    logic [2*OW-1:0]        p11_q;
    logic [2*OW-1:0]        p22_q;
    logic signed [2*OW-1:0] p12_q;
    logic                   en1_q;
    logic signed [2*OW:0]   sum_w;

    assign s1_w = {{OW{i_s1[OW-1]}}, i_s1};
    assign s2_w = {{OW{i_s2[OW-1]}}, i_s2};

    // Squares are non-negative and fit in 2*OW bits, so they are kept unsigned.
    assign sum_w = $signed({1'b0, p11_q}) + $signed({1'b0, p22_q})
                 - $signed({p12_q[2*OW-1], p12_q});

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            p11_q   <= '0;
            p22_q   <= '0;
            p12_q   <= '0;
            en1_q   <= 1'b0;
            o_power <= '0;
        end else begin
            en1_q <= i_en;
            if (i_en) begin
                p11_q <= s1_w * s1_w;
                p22_q <= s2_w * s2_w;
                p12_q <= s1_w * s2_w;
            end
            if (en1_q) begin
                o_power <= PW'(sum_w);
            end
        end
    end

endmodule

// File: rtl/goertzel_frame_ctrl.sv
// Frame sequencer for the fixed-bin (2cos = 1) Goertzel recursion.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_start        : begin a frame (IDLE only)
//   i_abort        : drop current frame/result, return to IDLE
//   i_continuous   : at result handshake, 1 = start next frame immediately
//   bus (slave)    : sample stream in, power result stream out
//   o_busy         : any state other than IDLE
//   o_sample_idx   : index of the next sample to accept
module goertzel_frame_ctrl
    import goertzel_pkg::*;
#(
    parameter int unsigned IW = DefIw,
    parameter int unsigned N  = DefN,
    parameter int unsigned OW = DefOw,
    parameter int unsigned PW = 2 * OW
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic                    i_continuous,
    goertzel_frame_ctrl_if.slave    bus,
    output logic                    o_busy,
    output logic [idx_width(N)-1:0] o_sample_idx
);

    localparam int unsigned XW = idx_width(N);
    localparam logic [XW-1:0] LastIdx = XW'(N - 1);

    state_e               state_q;
    logic signed [OW-1:0] s1_q;
    logic signed [OW-1:0] s2_q;
    logic [XW-1:0]        idx_q;
    logic                 pvalid_q;
    logic signed [OW-1:0] x_w;

    assign x_w = {{(OW - IW){bus.sample[IW-1]}}, bus.sample};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            s1_q     <= '0;
            s2_q     <= '0;
            idx_q    <= '0;
            pvalid_q <= 1'b0;
        end else if (i_abort && (state_q != StIdle)) begin
            // Abort beats every other event, including a same-cycle result handshake.
            state_q  <= StIdle;
            s1_q     <= '0;
            s2_q     <= '0;
            idx_q    <= '0;
            pvalid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q <= StAccum;
                        s1_q    <= '0;
                        s2_q    <= '0;
                        idx_q   <= '0;
                    end
                end
                StAccum: begin
                    if (bus.sample_valid) begin
                        s1_q <= x_w + s1_q - s2_q;
                        s2_q <= s1_q;
                        if (idx_q == LastIdx) begin
                            idx_q   <= '0;
                            state_q <= StMag1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                StMag1: state_q <= StMag2;
                StMag2: begin
                    // The power unit loads its result on this same edge.
                    state_q  <= StOut;
                    pvalid_q <= 1'b1;
                end
                StOut: begin
                    if (bus.power_ready) begin
                        pvalid_q <= 1'b0;
                        if (i_continuous) begin
                            state_q <= StAccum;
                            s1_q    <= '0;
                            s2_q    <= '0;
                            idx_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    goertzel_power #(
        .OW(OW),
        .PW(PW)
    ) u_power (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_en   (state_q == StMag1),
        .i_s1   (s1_q),
        .i_s2   (s2_q),
        .o_power(bus.power)
    );

    assign bus.sample_ready = (state_q == StAccum);
    assign bus.power_valid  = pvalid_q;
    assign o_busy           = (state_q != StIdle);
    assign o_sample_idx     = idx_q;

endmodule

// File: tb/tb_goertzel_frame_ctrl.sv
// Scoreboard bench for goertzel_frame_ctrl with N=6: stimulus pushes expected powers,
// a negedge monitor pops and compares on every result handshake.
module tb_goertzel_frame_ctrl;

    localparam int unsigned IW = 12;
    localparam int unsigned N  = 6;
    localparam int unsigned OW = 32;
    localparam int unsigned PW = 64;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic       i_abort;
    logic       i_continuous;
    logic       o_busy;
    logic [2:0] o_sample_idx;

    goertzel_frame_ctrl_if #(.IW(IW), .PW(PW)) bus ();

    goertzel_frame_ctrl #(
        .IW(IW),
        .N (N),
        .OW(OW),
        .PW(PW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_continuous(i_continuous),
        .bus         (bus),
        .o_busy      (o_busy),
        .o_sample_idx(o_sample_idx)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    longint unsigned exp_q[$];

    int imp[$]  = '{1, 0, 0, 0, 0, 0};
    int tone[$] = '{2, 1, -1, -2, -1, 1};
    int dc[$]   = '{1, 1, 1, 1, 1, 1};

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Goertzel with 2cos = 1 in plain integer arithmetic; int wraps at 32 bits like OW.
    function automatic longint unsigned ref_power(input int xs[$]);
        int s1 = 0;
        int s2 = 0;
        int t;
        longint a;
        longint b;
        foreach (xs[i]) begin
            t  = xs[i] + s1 - s2;
            s2 = s1;
            s1 = t;
        end
        a = s1;
        b = s2;
        return longint'(a * a + b * b - a * b);
    endfunction

    function automatic void rand_frame(output int xs[$]);
        xs = {};
        for (int i = 0; i < int'(N); i++) xs.push_back(int'($urandom_range(4095, 0)) - 2048);
    endfunction

    // Monitor: every handshake must match the oldest expected result.
    always @(negedge i_clk) begin
        if (i_rst_n && bus.power_valid && bus.power_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %0d expected none", bus.power);
            end else begin
                chk("power", bus.power, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_frame();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Returns #1 after the edge that accepted the last sample.
    task automatic send(input int xs[$], input int gap_max);
        int  g;
        int  n;
        bit  acc;
        foreach (xs[i]) begin
            g = int'($urandom_range(gap_max, 0));
            bus.sample_valid = 1'b0;
            repeat (g) tick();
            bus.sample_valid = 1'b1;
            bus.sample       = IW'(xs[i]);
            n = 0;
            do begin
                acc = bus.sample_ready;
                tick();
                n++;
            end while (!acc && n < 100);
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got ready=0 expected ready=1");
            end
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.power_valid && n < 50) begin
            tick();
            n++;
        end
        if (!bus.power_valid) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: got valid=0 expected valid=1");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 50) begin
            tick();
            n++;
        end
        if (o_busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int xs[$];
        int part_a[$];
        int part_b[$];
        longint unsigned e;

        i_rst_n          = 1'b0;
        i_start          = 1'b0;
        i_abort          = 1'b0;
        i_continuous     = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        bus.power_ready  = 1'b1;
        repeat (3) tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", bus.sample_ready, 0);
        chk("rst_valid", bus.power_valid, 0);
        chk("rst_power", bus.power, 0);
        chk("rst_idx", o_sample_idx, 0);
        i_rst_n = 1'b1;
        tick();

        // Impulse, back-to-back, with latency check.
        exp_q.push_back(64'd1);
        start_frame();
        chk("imp_busy", o_busy, 1);
        chk("imp_ready", bus.sample_ready, 1);
        chk("imp_idx0", o_sample_idx, 0);
        send(imp, 0);
        chk("imp_lat0_valid", bus.power_valid, 0);
        chk("imp_mag_ready", bus.sample_ready, 0);
        tick();
        chk("imp_lat1_valid", bus.power_valid, 0);
        tick();
        chk("imp_lat2_valid", bus.power_valid, 1);
        tick();
        chk("imp_post_busy", o_busy, 0);
        chk("imp_post_valid", bus.power_valid, 0);

        // Tone with gaps, then DC.
        exp_q.push_back(64'd36);
        start_frame();
        send(tone, 3);
        wait_idle();
        exp_q.push_back(64'd0);
        start_frame();
        send(dc, 2);
        wait_idle();

        // Backpressure: result held for 5 cycles.
        rand_frame(xs);
        e = ref_power(xs);
        exp_q.push_back(e);
        bus.power_ready = 1'b0;
        start_frame();
        send(xs, 2);
        wait_valid();
        repeat (5) begin
            tick();
            chk("bp_valid", bus.power_valid, 1);
            chk("bp_power", bus.power, e);
            chk("bp_sready", bus.sample_ready, 0);
        end
        bus.power_ready = 1'b1;
        wait_idle();
        repeat (5) tick();

        // Continuous: three frames, next frame starts right after handshake.
        i_continuous = 1'b1;
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd36);
        exp_q.push_back(64'd0);
        start_frame();
        send(imp, 0);
        repeat (3) tick();
        chk("cont1_ready", bus.sample_ready, 1);
        chk("cont1_idx", o_sample_idx, 0);
        chk("cont1_valid", bus.power_valid, 0);
        send(tone, 0);
        repeat (3) tick();
        chk("cont2_ready", bus.sample_ready, 1);
        chk("cont2_idx", o_sample_idx, 0);
        send(dc, 0);
        i_continuous = 1'b0;
        repeat (3) tick();
        chk("cont_end_busy", o_busy, 0);

        // Abort after 3 samples, then a clean impulse frame.
        start_frame();
        part_a = '{5, -3, 7};
        send(part_a, 1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_busy", o_busy, 0);
        chk("abort_ready", bus.sample_ready, 0);
        chk("abort_idx", o_sample_idx, 0);
        chk("abort_valid", bus.power_valid, 0);
        repeat (8) tick();
        exp_q.push_back(64'd1);
        start_frame();
        send(imp, 0);
        wait_idle();

        // Abort while presenting a result.
        rand_frame(xs);
        bus.power_ready = 1'b0;
        start_frame();
        send(xs, 1);
        wait_valid();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_out_valid", bus.power_valid, 0);
        chk("abort_out_busy", o_busy, 0);
        bus.power_ready = 1'b1;
        repeat (4) tick();

        // Start during ACCUM is ignored.
        rand_frame(xs);
        exp_q.push_back(ref_power(xs));
        part_a = xs[0:1];
        part_b = xs[2:5];
        start_frame();
        send(part_a, 0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_in_accum_idx", o_sample_idx, 2);
        send(part_b, 1);
        wait_idle();

        // Random frames.
        for (int k = 0; k < 4; k++) begin
            rand_frame(xs);
            exp_q.push_back(ref_power(xs));
            start_frame();
            send(xs, 2);
            wait_idle();
        end

        // Reset mid-ACCUM.
        start_frame();
        part_a = '{9, -9};
        send(part_a, 0);
        i_rst_n = 1'b0;
        tick();
        chk("rst_accum_busy", o_busy, 0);
        chk("rst_accum_ready", bus.sample_ready, 0);
        chk("rst_accum_idx", o_sample_idx, 0);
        i_rst_n = 1'b1;
        tick();

        // Reset while presenting a result.
        rand_frame(xs);
        bus.power_ready = 1'b0;
        start_frame();
        send(xs, 0);
        wait_valid();
        i_rst_n = 1'b0;
        tick();
        chk("rst_out_valid", bus.power_valid, 0);
        chk("rst_out_power", bus.power, 0);
        chk("rst_out_busy", o_busy, 0);
        i_rst_n = 1'b1;
        bus.power_ready = 1'b1;
        repeat (4) tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
